ysyx_22041211_alu_issue_buf: RTL and testbench
==============================================

// Module: ysyx_22041211_alu_issue_buf
// PURPOSE
//  ID->EX issue buffer directly upstream of the ALU: captures decoded instructions, selects ALU operands,
//  applies result forwarding, and presents src1/src2/alu_control to the ALU.
//  A 2-entry skid buffer decouples decode from EX back-pressure so in_ready is a pure register output.
//  Supports a synchronous flush (branch redirect) that discards all buffered work.
// PARAMETERS
//  DATA_LEN  32  operand/data width
//  REG_AW    5   register address width
// PORTS
//  clk             in   1         clock, rising edge
//  rst_n           in   1         asynchronous reset, active-low
//  in_valid        in   1         decode presents an instruction
//  in_ready        out  1         buffer can accept (registered)
//  in_pc           in   DATA_LEN  instruction PC
//  in_rs1_data     in   DATA_LEN  regfile rs1 read data
//  in_rs2_data     in   DATA_LEN  regfile rs2 read data
//  in_imm          in   DATA_LEN  sign-extended immediate
//  in_rs1_addr     in   REG_AW    rs1 index
//  in_rs2_addr     in   REG_AW    rs2 index
//  in_rd_addr      in   REG_AW    destination index
//  in_reg_wen      in   1         instruction writes rd
//  in_src1_sel     in   2         00 rs1, 01 pc, 10 zero, 11 zero
//  in_src2_sel     in   1         0 rs2, 1 imm
//  in_alu_control  in   4         ALU opcode, passed through unchanged
//  fwd_valid       in   1         a result is being written back this cycle
//  fwd_rd_addr     in   REG_AW    its destination index
//  fwd_data        in   DATA_LEN  its value
//  flush           in   1         discard all buffered and incoming instructions
//  out_valid       out  1         head entry valid to ALU
//  out_ready       in   1         EX accepts head entry this cycle
//  out_src1        out  DATA_LEN  ALU src1
//  out_src2        out  DATA_LEN  ALU src2
//  out_alu_control out  4         ALU opcode
//  out_pc          out  DATA_LEN  head PC
//  out_rd_addr     out  REG_AW    head rd
//  out_reg_wen     out  1         head write enable
// BEHAVIOUR
//  - Reset (rst_n=0, async): state EMPTY, both entries cleared; out_valid=0, in_ready=1, all other outputs 0.
//  - Entry = {pc, rs1_data, rs2_data, imm, rs1_addr, rs2_addr, rd_addr, reg_wen, src1_sel, src2_sel, alu_control}.
//  - States: EMPTY, ONE (head full), TWO (head+skid full). in_ready = (state!=TWO); out_valid = (state!=EMPTY).
//  - Fire: acc = in_valid&in_ready; pop = out_valid&out_ready.
//  - EMPTY: acc -> head<=in, ONE.  ONE: acc&pop -> head<=in, ONE; acc&!pop -> skid<=in, TWO; !acc&pop -> EMPTY.
//  - TWO: pop -> head<=skid, ONE; else hold. No capture in TWO (in_ready=0).
//  - Latency: in-handshake at edge N -> out_valid at N+1; full throughput 1/cycle when out_ready held 1.
//  - Order: strict FIFO; head always older than skid.
//  - Capture forwarding: if fwd_valid & fwd_rd_addr!=0 & fwd_rd_addr==in_rsX_addr, stored rsX_data = fwd_data.
//  - Hold forwarding: every cycle each valid stored entry (head and skid) whose rsX_addr matches
//    fwd_rd_addr (!=0, fwd_valid) updates its rsX_data to fwd_data; popped head is not updated.
//  - rd_addr==0 at capture: stored reg_wen forced 0.
//  - out_src1/out_src2: combinational mux of head entry per stored sel; zero when state EMPTY.
//  - flush: synchronous, highest priority; next state EMPTY, entries cleared, in_valid that cycle dropped,
//    pop that cycle still counted by EX (buffer does not care). in_ready=1 the cycle after.
//  - Reset asserted mid-transfer: all state lost immediately; no partial outputs after release.
// TESTING
//  1 Reset release, in_valid=1 addi(rs1=x5=7, imm=3, sel 00/1, ctl 0000), out_ready=1 -> next cycle out_valid=1, src1=7, src2=3.
//  2 out_ready=0, issue 3 back-to-back -> 2 accepted, in_ready=0 after 2nd; out_ready=1 -> drain in order, in_ready=1 again.
//  3 Held head rs2=x6, fwd_valid=1 rd=x6 data=0xDEAD during stall -> out_src2=0xDEAD next cycle; fwd to x0 -> no change.
//  4 TWO state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, incoming dropped.
//  5 src1_sel=01 pc=0x80000004, src2_sel=1 imm=-4 -> src1=0x80000004, src2=0xFFFFFFFC; rd=x0 wen=1 -> out_reg_wen=0.
//  6 Assert rst_n=0 while TWO -> out_valid=0 and outputs 0 immediately (before next clk edge).

Source files
------------

// File: rtl/ysyx_22041211_alu_issue_buf_if.sv
// Decode -> issue buffer -> ALU channel bundle.
// Carries the decode handshake, the write-back forwarding tap, the flush,
// and the ALU-side handshake.
// The buffer takes the slave view; the decode/EX environment takes the master view.
interface ysyx_22041211_alu_issue_buf_if #(
    parameter int DATA_LEN = 32,
    parameter int REG_AW   = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_LEN-1:0] in_pc;
    logic [DATA_LEN-1:0] in_rs1_data;
    logic [DATA_LEN-1:0] in_rs2_data;
    logic [DATA_LEN-1:0] in_imm;
    logic [REG_AW-1:0]   in_rs1_addr;
    logic [REG_AW-1:0]   in_rs2_addr;
    logic [REG_AW-1:0]   in_rd_addr;
    logic                in_reg_wen;
    logic [1:0]          in_src1_sel;
    logic                in_src2_sel;
    logic [3:0]          in_alu_control;

    logic                fwd_valid;
    logic [REG_AW-1:0]   fwd_rd_addr;
    logic [DATA_LEN-1:0] fwd_data;

    logic                flush;

    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] out_src1;
    logic [DATA_LEN-1:0] out_src2;
    logic [3:0]          out_alu_control;
    logic [DATA_LEN-1:0] out_pc;
    logic [REG_AW-1:0]   out_rd_addr;
    logic                out_reg_wen;

    modport master (
        output in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_rs1_addr, in_rs2_addr, in_rd_addr, in_reg_wen,
               in_src1_sel, in_src2_sel, in_alu_control,
               fwd_valid, fwd_rd_addr, fwd_data, flush, out_ready,
        input  in_ready, out_valid, out_src1, out_src2, out_alu_control,
               out_pc, out_rd_addr, out_reg_wen
    );

    modport slave (
        input  in_valid, in_pc, in_rs1_data, in_rs2_data, in_imm,
               in_rs1_addr, in_rs2_addr, in_rd_addr, in_reg_wen,
               in_src1_sel, in_src2_sel, in_alu_control,
               fwd_valid, fwd_rd_addr, fwd_data, flush, out_ready,
        output in_ready, out_valid, out_src1, out_src2, out_alu_control,
               out_pc, out_rd_addr, out_reg_wen
    );
endinterface

// File: rtl/ysyx_22041211_alu_issue_buf.sv
// ID->EX issue buffer: 2-entry skid buffer in front of the ALU with operand
// selection and write-back forwarding into both captured and held entries.
//
// state   | meaning
// --------+-------------------------------------------------
// S_EMPTY | nothing buffered, outputs forced to zero
// S_ONE   | head valid, skid free (can accept)
// S_TWO   | head and skid valid, in_ready low
module ysyx_22041211_alu_issue_buf #(
    parameter int DATA_LEN = 32,
    parameter int REG_AW   = 5
) (
    input  logic clk,
    input  logic rst_n,
    ysyx_22041211_alu_issue_buf_if.slave bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATA_LEN-1:0] pc;
        logic [DATA_LEN-1:0] rs1_data;
        logic [DATA_LEN-1:0] rs2_data;
        logic [DATA_LEN-1:0] imm;
        logic [REG_AW-1:0]   rs1_addr;
        logic [REG_AW-1:0]   rs2_addr;
        logic [REG_AW-1:0]   rd_addr;
        logic                reg_wen;
        logic [1:0]          src1_sel;
        logic                src2_sel;
        logic [3:0]          alu_control;
    } entry_t;

    state_t state, state_nxt;
    entry_t head, head_nxt;
    entry_t skid, skid_nxt;
    entry_t cap, head_upd, skid_upd;
    logic   in_ready_q;
    logic   acc, pop, out_valid;

    // Overwrite operand data of an entry with the value being written back
    // when it targets one of its sources (x0 never forwards).
    function automatic entry_t fwd_apply(input entry_t e, input logic fv,
                                         input logic [REG_AW-1:0] fa,
                                         input logic [DATA_LEN-1:0] fd);
        entry_t r;
        r = e;
        if (fv && fa != '0 && fa == e.rs1_addr) r.rs1_data = fd;
        if (fv && fa != '0 && fa == e.rs2_addr) r.rs2_data = fd;
        return r;
    endfunction

    assign out_valid = (state != S_EMPTY);
    assign acc       = bus.in_valid & in_ready_q;
    assign pop       = out_valid & bus.out_ready;

    // Build the entry to capture this cycle and the forwarded view of held entries.
    always_comb begin
        cap             = '0;
        cap.pc          = bus.in_pc;
        cap.rs1_data    = bus.in_rs1_data;
        cap.rs2_data    = bus.in_rs2_data;
        cap.imm         = bus.in_imm;
        cap.rs1_addr    = bus.in_rs1_addr;
        cap.rs2_addr    = bus.in_rs2_addr;
        cap.rd_addr     = bus.in_rd_addr;
        cap.reg_wen     = bus.in_reg_wen & (bus.in_rd_addr != '0);
        cap.src1_sel    = bus.in_src1_sel;
        cap.src2_sel    = bus.in_src2_sel;
        cap.alu_control = bus.in_alu_control;
        cap      = fwd_apply(cap,  bus.fwd_valid, bus.fwd_rd_addr, bus.fwd_data);
        head_upd = fwd_apply(head, bus.fwd_valid, bus.fwd_rd_addr, bus.fwd_data);
        skid_upd = fwd_apply(skid, bus.fwd_valid, bus.fwd_rd_addr, bus.fwd_data);
    end

    // Next-state and entry movement; flush overrides everything.
    always_comb begin
        state_nxt = state;
        head_nxt  = head_upd;
        skid_nxt  = skid_upd;
        unique case (state)
            S_EMPTY: begin
                if (acc) begin
                    head_nxt  = cap;
                    state_nxt = S_ONE;
                end
            end
            S_ONE: begin
                if (acc && pop) begin
                    head_nxt = cap;
                end else if (acc) begin
                    skid_nxt  = cap;
                    state_nxt = S_TWO;
                end else if (pop) begin
                    state_nxt = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    head_nxt  = skid_upd;
                    state_nxt = S_ONE;
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
        if (bus.flush) begin
            state_nxt = S_EMPTY;
            head_nxt  = '0;
            skid_nxt  = '0;
        end
    end

    // State, entries and the registered in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_EMPTY;
            head       <= '0;
            skid       <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            head       <= head_nxt;
            skid       <= skid_nxt;
            in_ready_q <= (state_nxt != S_TWO);
        end
    end

    // ALU operand mux from the head entry; everything reads zero when empty.
    always_comb begin
        bus.out_src1 = '0;
        bus.out_src2 = '0;
        if (out_valid) begin
            case (head.src1_sel)
                2'b00:   bus.out_src1 = head.rs1_data;
                2'b01:   bus.out_src1 = head.pc;
                default: bus.out_src1 = '0;
            endcase
            bus.out_src2 = head.src2_sel ? head.imm : head.rs2_data;
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid;
    assign bus.out_alu_control = out_valid ? head.alu_control : 4'd0;
    assign bus.out_pc          = out_valid ? head.pc : '0;
    assign bus.out_rd_addr     = out_valid ? head.rd_addr : '0;
    assign bus.out_reg_wen     = out_valid & head.reg_wen;

endmodule

// File: tb/tb_ysyx_22041211_alu_issue_buf.sv
// Directed bench for the ALU issue buffer: issue, skid/back-pressure,
// forwarding, flush, operand select and asynchronous reset.
module tb_ysyx_22041211_alu_issue_buf;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ysyx_22041211_alu_issue_buf_if #(.DATA_LEN(32), .REG_AW(5)) bus ();

    ysyx_22041211_alu_issue_buf #(.DATA_LEN(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] pc, input logic [31:0] rs1d,
                          input logic [31:0] rs2d, input logic [31:0] imm,
                          input logic [4:0] rs1a, input logic [4:0] rs2a,
                          input logic [4:0] rd, input logic wen,
                          input logic [1:0] s1, input logic s2,
                          input logic [3:0] ctl);
        bus.in_valid       = 1'b1;
        bus.in_pc          = pc;
        bus.in_rs1_data    = rs1d;
        bus.in_rs2_data    = rs2d;
        bus.in_imm         = imm;
        bus.in_rs1_addr    = rs1a;
        bus.in_rs2_addr    = rs2a;
        bus.in_rd_addr     = rd;
        bus.in_reg_wen     = wen;
        bus.in_src1_sel    = s1;
        bus.in_src2_sel    = s2;
        bus.in_alu_control = ctl;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_pc = '0; bus.in_rs1_data = '0; bus.in_rs2_data = '0; bus.in_imm = '0;
        bus.in_rs1_addr = '0; bus.in_rs2_addr = '0; bus.in_rd_addr = '0;
        bus.in_reg_wen = 1'b0; bus.in_src1_sel = 2'b00; bus.in_src2_sel = 1'b0;
        bus.in_alu_control = 4'd0;
        bus.fwd_valid = 1'b0; bus.fwd_rd_addr = '0; bus.fwd_data = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;

        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_src1",      bus.out_src1,       32'd0);
        chk("rst_src2",      bus.out_src2,       32'd0);
        chk("rst_pc",        bus.out_pc,         32'd0);
        rst_n = 1'b1;

        // 1: addi x1, x5(=7), 3
        set_in(32'h100, 32'd7, 32'd0, 32'd3, 5'd5, 5'd0, 5'd1, 1'b1, 2'b00, 1'b1, 4'd0);
        bus.out_ready = 1'b1;
        tick();
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_src1",      bus.out_src1,       32'd7);
        chk("t1_src2",      bus.out_src2,       32'd3);
        chk("t1_pc",        bus.out_pc,         32'h100);
        chk("t1_rd",        32'(bus.out_rd_addr), 32'd1);
        chk("t1_wen",       32'(bus.out_reg_wen), 32'd1);
        bus.in_valid = 1'b0;
        tick();
        chk("t1_drained", 32'(bus.out_valid), 32'd0);

        // 2: back-pressure, three back-to-back issues, only two fit
        bus.out_ready = 1'b0;
        set_in(32'h200, 32'd1, 32'h11, 32'd0, 5'd10, 5'd11, 5'd2, 1'b1, 2'b00, 1'b0, 4'd1);
        tick();
        chk("t2_ready_one", 32'(bus.in_ready), 32'd1);
        set_in(32'h204, 32'd2, 32'h22, 32'd0, 5'd12, 5'd13, 5'd3, 1'b1, 2'b00, 1'b0, 4'd2);
        tick();
        chk("t2_ready_two", 32'(bus.in_ready), 32'd0);
        chk("t2_head_pc",   bus.out_pc,        32'h200);
        set_in(32'h208, 32'd3, 32'h33, 32'd0, 5'd14, 5'd15, 5'd4, 1'b1, 2'b00, 1'b0, 4'd3);
        tick();
        chk("t2_stall_pc",    bus.out_pc,        32'h200);
        chk("t2_stall_ready", 32'(bus.in_ready), 32'd0);
        chk("t2_head_ctl",    32'(bus.out_alu_control), 32'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("t2_second_pc",  bus.out_pc,        32'h204);
        chk("t2_second_s1",  bus.out_src1,      32'd2);
        chk("t2_second_s2",  bus.out_src2,      32'h22);
        chk("t2_ready_back", 32'(bus.in_ready), 32'd1);
        tick();
        chk("t2_empty", 32'(bus.out_valid), 32'd0);

        // 3: hold forwarding into a stalled head, x0 ignored, capture forwarding
        bus.out_ready = 1'b0;
        set_in(32'h240, 32'h10, 32'h20, 32'd0, 5'd3, 5'd6, 5'd7, 1'b1, 2'b00, 1'b0, 4'd5);
        tick();
        bus.in_valid    = 1'b0;
        bus.fwd_valid   = 1'b1;
        bus.fwd_rd_addr = 5'd6;
        bus.fwd_data    = 32'hDEAD;
        tick();
        chk("t3_fwd_src2", bus.out_src2, 32'hDEAD);
        chk("t3_fwd_src1", bus.out_src1, 32'h10);
        bus.fwd_rd_addr = 5'd0;
        bus.fwd_data    = 32'hBEEF;
        tick();
        chk("t3_x0_src2", bus.out_src2, 32'hDEAD);
        bus.fwd_rd_addr = 5'd3;
        bus.fwd_data    = 32'h33;
        set_in(32'h300, 32'h99, 32'h44, 32'd0, 5'd3, 5'd4, 5'd8, 1'b1, 2'b00, 1'b0, 4'd6);
        tick();
        chk("t3_hold_src1",  bus.out_src1,      32'h33);
        chk("t3_two_ready",  32'(bus.in_ready), 32'd0);
        bus.fwd_valid = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("t3_cap_src1", bus.out_src1, 32'h33);
        chk("t3_cap_src2", bus.out_src2, 32'h44);
        chk("t3_cap_pc",   bus.out_pc,   32'h300);

        // 4: flush from TWO with a simultaneous incoming instruction
        bus.out_ready = 1'b0;
        set_in(32'h304, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd9, 1'b1, 2'b00, 1'b0, 4'd7);
        tick();
        chk("t4_two", 32'(bus.in_ready), 32'd0);
        set_in(32'h308, 32'd5, 32'd6, 32'd0, 5'd1, 5'd2, 5'd9, 1'b1, 2'b00, 1'b0, 4'd8);
        bus.flush = 1'b1;
        tick();
        chk("t4_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_in_ready",  32'(bus.in_ready),  32'd1);
        chk("t4_src1",      bus.out_src1,       32'd0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("t4_dropped", 32'(bus.out_valid), 32'd0);

        // 5: pc/imm operand select, rd=x0 kills write enable
        set_in(32'h80000004, 32'd5, 32'd9, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, 1'b1, 2'b01, 1'b1, 4'hA);
        tick();
        chk("t5_src1", bus.out_src1, 32'h80000004);
        chk("t5_src2", bus.out_src2, 32'hFFFFFFFC);
        chk("t5_wen",  32'(bus.out_reg_wen), 32'd0);
        chk("t5_ctl",  32'(bus.out_alu_control), 32'hA);
        set_in(32'h10, 32'd5, 32'd9, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1, 2'b10, 1'b0, 4'd1);
        tick();
        chk("t5_two", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;

        // 6: asynchronous reset while full
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_in_ready",  32'(bus.in_ready),  32'd1);
        chk("t6_src1",      bus.out_src1,       32'd0);
        chk("t6_src2",      bus.out_src2,       32'd0);
        chk("t6_pc",        bus.out_pc,         32'd0);
        chk("t6_ctl",       32'(bus.out_alu_control), 32'd0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        chk("t6_after_release", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
